// File: rtl/rgb_key_reader.sv
// rgb_key_reader
// Four-position RGB code entry from raw pushbuttons. Each btn[i] steps the
// 3-bit colour field of one LED position (btn[3] -> position 1 in code[11:9],
// btn[0] -> position 4 in code[2:0]). btn_ok submits the code and compares it
// with the pattern loaded by expect_vld.
//
// Optional feature: define RGB_KEY_TIMEOUT_EN to build an idle counter that
// forces a submit after TIMEOUT_CYCLES quiet cycles in ENTRY; the timeout
// output then flags a forced submit. Without the macro timeout is tied low.
//
// The target-pattern input is named expect_code because "expect" is a
// reserved word in SystemVerilog.
//
// state | meaning
// IDLE  | no round loaded; code and match held at zero
// ENTRY | round active; presses edit code, ok (or idle timeout) submits
// DONE  | result held; presses ignored until the next expect_vld

module rgb_key_reader #(
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic        btn_ok,
  input  logic [11:0] expect_code,
  input  logic        expect_vld,
  output logic [11:0] code,
  output logic        code_vld,
  output logic        match,
  output logic        busy,
  output logic        timeout
);

  // btn[3:0] occupy bits 3:0 of the button vectors, btn_ok sits in bit 4
  localparam int NB = 5;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync1_d;
  logic [NB-1:0] sync2_q, sync2_d;
  logic [NB-1:0] level_q, level_d;
  logic [NB-1:0] press_q, press_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  state_t        state_q, state_d;
  logic [11:0]   code_q, code_d;
  logic [11:0]   exp_q, exp_d;
  logic          code_vld_q, code_vld_d;
  logic          match_q, match_d;
  logic          busy_q, busy_d;

  logic [3:0]    btn_press;
  logic          ok_press;
  logic          tmo_hit;

  assign raw = {btn_ok, btn};

  // synchronizer shift and per-button debounce; the counter only advances
  // while the synchronized sample disagrees with the accepted level
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      press_d[i] = level_d[i] & ~level_q[i];
    end
  end

  // synchronizer, debounce and press-event registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_press = press_q[3:0];
  assign ok_press  = press_q[4];

`ifdef RGB_KEY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;

  // idle down-counter: held at full count outside ENTRY and on any activity
  always_comb begin
    tmo_d = tmo_q;
    if ((state_q != S_ENTRY) || expect_vld || (|press_q)) begin
      tmo_d = TMO_LAST;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  // idle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (state_q == S_ENTRY) && (tmo_q == '0) && !(|press_q);
  assign timeout = timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
  assign timeout        = 1'b0;
`endif

  // round control: expect_vld beats ok, ok beats timeout, submit beats edits
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    exp_d      = exp_q;
    code_vld_d = 1'b0;
    match_d    = match_q;
    busy_d     = busy_q;
`ifdef RGB_KEY_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        code_d  = '0;
        match_d = 1'b0;
        if (expect_vld) begin
          exp_d   = expect_code;
          state_d = S_ENTRY;
          busy_d  = 1'b1;
        end
      end
      S_ENTRY: begin
        if (expect_vld) begin
          exp_d  = expect_code;
          code_d = '0;
        end else if (ok_press || tmo_hit) begin
          match_d    = (code_q == exp_q);
          code_vld_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_DONE;
`ifdef RGB_KEY_TIMEOUT_EN
          timeout_d  = ~ok_press;
`endif
        end else begin
          for (int p = 0; p < 4; p++) begin
            if (btn_press[p]) begin
              code_d[p*3 +: 3] = code_q[p*3 +: 3] + 3'd1;
            end
          end
        end
      end
      S_DONE: begin
        if (expect_vld) begin
          exp_d   = expect_code;
          code_d  = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ENTRY;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = '0;
        match_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      exp_q      <= '0;
      code_vld_q <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RGB_KEY_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      exp_q      <= exp_d;
      code_vld_q <= code_vld_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
`ifdef RGB_KEY_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign code     = code_q;
  assign code_vld = code_vld_q;
  assign match    = match_q;
  assign busy     = busy_q;

endmodule

// File: doc/rgb_key_reader.md
RGB_KEY_READER -- requirements
Module: rgb_key_reader

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: idle cycles in ENTRY before a forced submit; used only with TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 btn  input  4  raw pushbuttons; btn[3] edits LED position 1, btn[0] edits LED position 4.
REQ-006 btn_ok  input  1  raw submit pushbutton.
REQ-007 expect  input  12  target pattern, same packing as code.
REQ-008 expect_vld  input  1  one-cycle strobe; load expect and start a round.
REQ-009 code  output  12  entered pattern: {pos1 r,g,b, pos2 r,g,b, pos3 r,g,b, pos4 r,g,b}, so pos1 is bits 11:9.
REQ-010 code_vld  output  1  one-cycle pulse on submit.
REQ-011 match  output  1  registered (code == latched expect) at submit; held until the next round.
REQ-012 busy  output  1  high in ENTRY.
REQ-013 timeout  output  1  high when the last submit was forced by timeout.

Function
REQ-014 Each raw button input (btn[3:0], btn_ok) shall pass through a 2-flop synchronizer, then a debouncer.
REQ-015 Debouncer: a per-button counter increments while the synchronized sample differs from the debounced level and clears otherwise; when the count reaches DEB_CYCLES, the debounced level takes the sample.
REQ-016 A press event shall be a single-cycle pulse on a 0->1 transition of a debounced level. Latency from a stable raw edge to the event shall be 2+DEB_CYCLES cycles, +/-1.
REQ-017 FSM states: IDLE, ENTRY, DONE.
REQ-018 IDLE: code=0, match=0, busy=0. On expect_vld, latch expect, clear code and go to ENTRY.
REQ-019 ENTRY: busy=1.
  - A press on btn[i] increments that position's 3-bit field modulo 8 (111 -> 000 wrap).
  - Simultaneous presses on several positions all apply in the same cycle.
REQ-020 ENTRY, on an ok press:
  - register match and set timeout=0;
  - pulse code_vld the following cycle;
  - go to DONE.
  - Any btn increments in the same cycle are discarded.
REQ-021 ENTRY, on expect_vld: re-latch expect, clear code, stay in ENTRY, no code_vld. expect_vld takes priority over an ok press in the same cycle.
REQ-022 DONE: code, match and timeout hold; btn and ok presses are ignored. On expect_vld, latch expect, clear code and go to ENTRY.
REQ-023 code_vld shall never be high for two consecutive cycles.
REQ-024 Debouncers run in every state; a button held across a state change shall not produce a new event.

Reset
REQ-025 While rst=0, asynchronously:
  - state=IDLE;
  - code=0, code_vld=0, match=0, busy=0, timeout=0;
  - latched expect=0;
  - synchronizers, debounced levels and counters=0.
REQ-026 Reset asserted mid-ENTRY shall abort the round with no code_vld.
REQ-027 After release, a button already held shall give a press event once debounced.

Configuration
REQ-028 Macro RGB_KEY_TIMEOUT_EN, when defined:
  - an idle counter runs in ENTRY and clears on any press event or on expect_vld;
  - when it reaches TIMEOUT_CYCLES, the block performs the REQ-020 submit with timeout=1.
REQ-029 Macro RGB_KEY_TIMEOUT_EN, when undefined: no timeout counter is built, timeout is tied to 0, and ENTRY waits indefinitely.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-030 Basic round: expect_vld with expect=12'hFFF; 7 clean presses on each btn[i]; ok -> code=12'hFFF, match=1, one code_vld pulse.
REQ-031 Wrap: 9 presses of btn[3] -> code=12'h200; ok with expect=12'h200 -> match=1.
REQ-032 Bounce: btn[1] toggling every cycle for 3 cycles, then stable high -> exactly one increment; a glitch of 3 cycles or fewer -> no increment.
REQ-033 Priority: ok press, btn[0] press and expect_vld in the same cycle -> no code_vld, code=0, still ENTRY. Then ok alone -> match=(0==new expect).
REQ-034 Reset: rst low mid-ENTRY with code=12'h123 -> all outputs 0 within the same cycle, IDLE; presses in IDLE do not change code.
REQ-035 Timeout: with RGB_KEY_TIMEOUT_EN, 50 idle cycles in ENTRY -> code_vld, timeout=1. Without the macro, 200 idle cycles -> busy stays 1, timeout=0.
